// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port A arbiter.
// Holds the FSM state encoding, word geometry and requester ids.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN,
    DONE
  } arb_state_t;

  localparam int BYTES_PER_WORD = 4;

  localparam logic REQ_SEL = 1'b0;
  localparam logic REQ_CPU = 1'b1;

endpackage

// File: rtl/word_byte_sequencer.sv
// Splits one 32-bit access into four little-endian byte accesses.
// In: active/we/base_addr/wdata/ram_readdata; out: RAM port, cap_word/cap_last.
module word_byte_sequencer
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic              we,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       wdata,
  input  logic [7:0]        ram_readdata,
  output logic              last_byte,
  output logic [ADDR_W-1:0] ram_address,
  output logic [7:0]        ram_writedata,
  output logic              ram_write_enable,
  output logic [31:0]       cap_word,
  output logic              cap_last
);

  logic [1:0]        k;
  logic [RD_LAT-1:0] pv;
  logic [1:0]        pk [RD_LAT];
  logic [31:0]       rword;
  logic              cap_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= '0;
    end else if (active) begin
      k <= k + 2'd1;
    end else begin
      k <= '0;
    end
  end

  assign last_byte = active && (k == 2'(BYTES_PER_WORD - 1));

  // address add is done at ADDR_W bits so it wraps at the top of RAM
  assign ram_address      = active ? base_addr + ADDR_W'(k) : '0;
  assign ram_write_enable = active && we;
  assign ram_writedata    = ram_write_enable ?
                            wdata[{k, 3'b000} +: 8] : '0;

  // read issue marker + lane index, delayed to line up with q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < RD_LAT; i++) pk[i] <= '0;
    end else begin
      pv[0] <= active && !we;
      pk[0] <= k;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pk[i] <= pk[i-1];
      end
    end
  end

  assign cap_valid = pv[RD_LAT-1];
  assign cap_last  = cap_valid && (pk[RD_LAT-1] == 2'd3);

  // bytes arrive in lane order, so shifting in from the top
  // leaves byte 0 in [7:0] after the fourth capture
  assign cap_word = {ram_readdata, rword[31:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rword <= '0;
    end else if (cap_valid) begin
      rword <= cap_word;
    end
  end

endmodule

// File: rtl/ram_porta_arbiter.sv
// Round-robin share of 8-bit RAM port A between two 32-bit requesters.
// Ports: r0_*/r1_* requester buses, ram_* port A, busy/owner status.
module ram_porta_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [31:0]       r0_wdata,
  output logic [31:0]       r0_rdata,
  output logic              r0_done,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [31:0]       r1_wdata,
  output logic [31:0]       r1_rdata,
  output logic              r1_done,
  output logic [ADDR_W-1:0] ram_address,
  output logic [7:0]        ram_writedata,
  output logic              ram_write_enable,
  input  logic [7:0]        ram_readdata,
  output logic              busy,
  output logic              owner
);

  arb_state_t        state, nstate;
  logic              rr_last;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic              any_req, gnt;
  logic              last_byte, cap_last;
  logic [31:0]       cap_word;

  assign any_req = r0_req || r1_req;
  // on a tie the requester not served last wins
  assign gnt = (r0_req && r1_req) ? !rr_last : r1_req;

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (any_req) nstate = XFER;
      XFER:  if (last_byte) nstate = lat_we ? DONE : DRAIN;
      DRAIN: if (cap_last) nstate = DONE;
      DONE:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= REQ_SEL;
      rr_last   <= REQ_CPU;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= nstate;
      if (state == IDLE && any_req) begin
        owner     <= gnt;
        rr_last   <= gnt;
        lat_we    <= gnt ? r1_we : r0_we;
        lat_addr  <= gnt ? r1_addr : r0_addr;
        lat_wdata <= gnt ? r1_wdata : r0_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else if (state == DRAIN && cap_last) begin
      if (owner == REQ_CPU) r1_rdata <= cap_word;
      else                  r0_rdata <= cap_word;
    end
  end

  assign busy    = (state != IDLE);
  assign r0_done = (state == DONE) && (owner == REQ_SEL);
  assign r1_done = (state == DONE) && (owner == REQ_CPU);

  word_byte_sequencer #(
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT)
  ) u_seq (
    .clk              (clk),
    .rst              (rst),
    .active           (state == XFER),
    .we               (lat_we),
    .base_addr        (lat_addr),
    .wdata            (lat_wdata),
    .ram_readdata     (ram_readdata),
    .last_byte        (last_byte),
    .ram_address      (ram_address),
    .ram_writedata    (ram_writedata),
    .ram_write_enable (ram_write_enable),
    .cap_word         (cap_word),
    .cap_last         (cap_last)
  );

endmodule

// File: tb/tb_ram_porta_arbiter.sv
// Scoreboard bench for ram_porta_arbiter with a byte-array reference.
// Drives directed and random request pairs; a monitor checks port/done.
module tb_ram_porta_arbiter;

  localparam int AW  = 19;
  localparam int RDL = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_req, r0_we, r1_req, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [31:0]   r0_wdata, r1_wdata, r0_rdata, r1_rdata;
  logic          r0_done, r1_done;
  logic [AW-1:0] ram_address;
  logic [7:0]    ram_writedata, ram_readdata;
  logic          ram_write_enable, busy, owner;

  ram_porta_arbiter #(.ADDR_W(AW), .RD_LAT(RDL)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_rdata(r0_rdata), .r0_done(r0_done),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_rdata(r1_rdata), .r1_done(r1_done),
    .ram_address(ram_address), .ram_writedata(ram_writedata),
    .ram_write_enable(ram_write_enable), .ram_readdata(ram_readdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  bit [7:0] mem [0:(1<<AW)-1];
  bit [7:0] rd_pipe [RDL];

  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_address] <= ram_writedata;
    rd_pipe[0] <= mem[ram_address];
    for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_readdata = rd_pipe[RDL-1];

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } pev_t;

  typedef struct {
    bit          who;
    bit          we;
    logic [31:0] rdata;
    int          cyc;
  } dev_t;

  pev_t        portq[$];
  dev_t        doneq[$];
  bit [7:0]    ref_mem [int];
  logic [31:0] last_rd [2];
  bit          rr_m;
  int          cyc = 0;
  int          vecs = 0;
  int          errs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cyc %0d", n, act, exp, cyc);
    end
  endtask

  task automatic fail(input string n, input logic [63:0] act,
                      input logic [63:0] exp);
    vecs++;
    errs++;
    $display("FAIL %s: got %0h expected %0h at cyc %0d", n, act, exp, cyc);
  endtask

  function automatic bit [7:0] ref_get(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
  endfunction

  // one transaction in service order; returns its done cycle
  function automatic int model(input bit who, input bit we,
                               input logic [AW-1:0] a,
                               input logic [31:0] wd, input int c0);
    dev_t          e;
    logic [AW-1:0] ak;
    logic [31:0]   rd;
    rd = '0;
    for (int k = 0; k < 4; k++) begin
      ak = AW'(a + k);
      if (we) begin
        portq.push_back('{ak, wd[8*k +: 8]});
        ref_mem[int'(ak)] = wd[8*k +: 8];
      end else begin
        rd[8*k +: 8] = ref_get(ak);
      end
    end
    if (!we) last_rd[who] = rd;
    e.who   = who;
    e.we    = we;
    e.rdata = last_rd[who];
    e.cyc   = c0 + 5 + (we ? 0 : RDL);
    doneq.push_back(e);
    rr_m = who;
    return e.cyc;
  endfunction

  always @(negedge clk) begin
    pev_t p;
    dev_t e;
    if (!rst) begin
      check("done_excl", {63'd0, r0_done & r1_done}, 64'd0);
      if (ram_write_enable) begin
        if (portq.size() == 0) begin
          fail("spurious_write", {ram_address, ram_writedata}, 0);
        end else begin
          p = portq.pop_front();
          check("wr_addr", ram_address, p.addr);
          check("wr_data", ram_writedata, p.data);
        end
      end
      if (!busy)
        check("idle_port", {ram_write_enable, ram_address, ram_writedata}, 0);
      if (r0_done || r1_done) begin
        if (doneq.size() == 0) begin
          fail("spurious_done", {r1_done, r0_done}, 0);
        end else begin
          e = doneq.pop_front();
          check("done_who", r1_done, e.who);
          check("done_cyc", cyc, e.cyc);
          check("owner", owner, e.who);
          check(e.we ? "rdata_hold" : "rdata",
                e.who ? r1_rdata : r0_rdata, e.rdata);
        end
      end
    end
  end

  task automatic run_pair(input bit en0, input bit en1,
                          input int s0, input int s1,
                          input bit we0, input logic [AW-1:0] a0,
                          input logic [31:0] w0,
                          input bit we1, input logic [AW-1:0] a1,
                          input logic [31:0] w1);
    bit first, got0, got1;
    int c, d, t;
    @(negedge clk);
    c = cyc;
    if (en0 && en1) first = (s0 == s1) ? !rr_m : (s1 < s0);
    else            first = en1;
    if (!first) d = model(1'b0, we0, a0, w0, c + s0);
    else        d = model(1'b1, we1, a1, w1, c + s1);
    if (en0 && en1) begin
      if (!first) void'(model(1'b1, we1, a1, w1, d + 1));
      else        void'(model(1'b0, we0, a0, w0, d + 1));
    end
    got0 = !en0;
    got1 = !en1;
    t = 0;
    while (1) begin
      if (en0 && t == s0) begin
        r0_we = we0; r0_addr = a0; r0_wdata = w0; r0_req = 1'b1;
      end
      if (en1 && t == s1) begin
        r1_we = we1; r1_addr = a1; r1_wdata = w1; r1_req = 1'b1;
      end
      if (r0_done) begin got0 = 1'b1; r0_req = 1'b0; end
      if (r1_done) begin got1 = 1'b1; r1_req = 1'b0; end
      if (got0 && got1) break;
      if (t == 100) begin
        fail("timeout", {got1, got0}, 2'b11);
        r0_req = 1'b0;
        r1_req = 1'b0;
        break;
      end
      @(negedge clk);
      t++;
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 31));
  endfunction

  initial begin
    bit            e0, e1, who1st, w0, w1;
    int            sl;
    logic [AW-1:0] a0, a1;

    rst = 1'b1;
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
    rr_m = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_port", {ram_write_enable, ram_address, ram_writedata}, 0);
    check("rst_done", {r1_done, r0_done}, 0);
    check("rst_rdata", {r1_rdata, r0_rdata}, 0);
    rst = 1'b0;

    // tie from reset: r0 first, then r1, twice
    run_pair(1, 1, 0, 0, 1, 19'h00100, 32'h01020304,
                         1, 19'h00200, 32'h05060708);
    run_pair(1, 1, 0, 0, 0, 19'h00200, 32'h0,
                         0, 19'h00100, 32'h0);
    // single write, then preload + read back from r1
    run_pair(1, 0, 0, 0, 1, 19'h30E50, 32'h00030E50, 0, '0, '0);
    run_pair(1, 0, 0, 0, 1, 19'h30E50, 32'h44332211, 0, '0, '0);
    run_pair(0, 1, 0, 0, 0, '0, '0, 0, 19'h30E50, '0);
    // wrap-around at the top of RAM
    run_pair(0, 1, 0, 0, 0, '0, '0, 1, 19'h7FFFE, 32'hAABBCCDD);
    run_pair(1, 0, 0, 0, 0, 19'h7FFFF, '0, 0, '0, '0);
    // r1 arrives during r0's byte 2
    run_pair(1, 1, 0, 3, 1, 19'h00040, 32'hCAFEF00D,
                         0, 19'h00040, '0);

    // reset abort after byte 1 of a write
    @(negedge clk);
    r0_we = 1'b1; r0_addr = 19'h30E50; r0_wdata = 32'hDEADBEEF;
    r0_req = 1'b1;
    portq.push_back('{19'h30E50, 8'hEF});
    portq.push_back('{19'h30E51, 8'hBE});
    ref_mem[32'h30E50] = 8'hEF;
    ref_mem[32'h30E51] = 8'hBE;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    r0_req = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_port", {ram_write_enable, ram_address, ram_writedata}, 0);
    check("abort_done", {r1_done, r0_done}, 0);
    check("abort_rdata", {r1_rdata, r0_rdata}, 0);
    rr_m = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_pair(0, 1, 0, 0, 0, '0, '0, 0, 19'h30E50, '0);

    for (int n = 0; n < 150; n++) begin
      e0 = 1'($urandom);
      e1 = 1'($urandom);
      if (!e0 && !e1) e0 = 1'b1;
      sl = (e0 && e1) ? $urandom_range(0, 4) : 0;
      who1st = 1'($urandom);
      w0 = 1'($urandom);
      w1 = 1'($urandom);
      a0 = rand_addr();
      a1 = rand_addr();
      run_pair(e0, e1, who1st ? sl : 0, who1st ? 0 : sl,
               w0, a0, $urandom, w1, a1, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("portq_empty", portq.size(), 0);
    check("doneq_empty", doneq.size(), 0);
    foreach (ref_mem[a]) check("ram_final", mem[AW'(a)], ref_mem[a]);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ram_porta_arbiter.md
Name: ram_porta_arbiter

Overview:
- Shares the single 8-bit port A of the dual-port frame/data RAM between two 32-bit requesters: requester 0 (selection/control writer) and requester 1 (CPU data path).
- Serialises each granted 32-bit read or write into four little-endian byte accesses on the RAM port.
- Replaces the mode-driven static mux on port A. Port B remains owned by the VGA reader.

Parameters:
- ADDR_W, 19, RAM byte-address width.
- RD_LAT, 1, cycles from address presented to ram_readdata valid; legal values 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- r0_req  in  1  requester 0 transaction request (level).
- r0_we  in  1  1 = write, 0 = read.
- r0_addr  in  ADDR_W  byte base address.
- r0_wdata  in  32  write word.
- r0_rdata  out  32  read word.
- r0_done  out  1  one-cycle completion pulse.
- r1_req, r1_we, r1_addr, r1_wdata, r1_rdata, r1_done: same as r0_*, for requester 1.
- ram_address  out  ADDR_W  port A address.
- ram_writedata  out  8  port A write byte.
- ram_write_enable  out  1  port A write enable.
- ram_readdata  in  8  port A q.
- busy  out  1  transaction in progress.
- owner  out  1  current grantee; valid while busy.

Behaviour:
- Reset values: all outputs 0; rr_last = 1, so requester 0 wins the first tie; byte counter = 0; state = IDLE.
- States: IDLE, XFER, DRAIN, DONE.
- IDLE:
  - Samples r0_req and r1_req each cycle.
  - One requester asserted: grant it.
  - Both asserted: grant the one not equal to rr_last.
  - On grant: latch we, addr and wdata of the grantee, set owner, set rr_last = grantee, go to XFER.
- XFER (4 cycles, k = 0..3):
  - ram_address = latched_addr + k, truncated to ADDR_W, so the address wraps modulo 2^ADDR_W.
  - Write: ram_writedata = wdata[8k+7:8k] and ram_write_enable = 1.
  - Read: ram_write_enable = 0.
  - After k = 3: write goes to DONE; read goes to DRAIN.
- DRAIN (RD_LAT cycles): finishes capture of the outstanding read bytes. Goes to DONE.
- Read capture: ram_readdata sampled RD_LAT cycles after byte k's address is written into rdata[8k+7:8k] of the owner's register.
- DONE (1 cycle): owner's done = 1, then go to IDLE.
- Latency, with req sampled at end of cycle 0:
  - Write: bytes written at the ends of cycles 1–4; done in cycle 5.
  - Read: done in cycle 5+RD_LAT.
- busy = (state != IDLE).
- Outside XFER: ram_write_enable = 0, ram_address = 0, ram_writedata = 0.
- rN_rdata holds its value until that requester's next read completes. Writes never modify rN_rdata.
- Requester rules:
  - Hold req, we, addr and wdata stable until done.
  - Deassert req no later than the cycle after done. req still high when IDLE samples it = a new transaction.
- Req dropped mid-transaction: ignored; the transaction completes and done still pulses.
- Request from the non-owner while busy: waits; arbitrated in the next IDLE cycle, so there is no starvation under round-robin.
- Reset mid-transaction: immediate abort; outputs return to reset values; bytes already written stay in RAM; no done pulse.
- r0_done and r1_done are never high in the same cycle.

Decomposition:
- Package ram_arb_pkg:
  - arb_state_t enum {IDLE, XFER, DRAIN, DONE}.
  - BYTES_PER_WORD = 4.
  - Requester index constants REQ_SEL = 0, REQ_CPU = 1.
- Sub-module word_byte_sequencer: owns the byte counter, address increment/wrap, byte-lane select for writes and the RD_LAT-delayed capture shift for reads.
- The top level keeps only arbitration, the FSM and the per-requester rdata/done registers.

Test Plan:
- Single write: r0 writes 0x00030E50 to 0x30E50 -> in cycles 1–4, ram_address = 0x30E50..0x30E53, writedata = 50, 0E, 03, 00, wren = 1; r0_done pulses in cycle 5; RAM model holds those bytes.
- Single read: RAM preloaded 0x30E50..0x30E53 = 11, 22, 33, 44; r1 reads 0x30E50 with RD_LAT = 1 -> r1_rdata = 0x44332211 and r1_done in cycle 6; repeat with RD_LAT = 2 -> done in cycle 7.
- Tie and round-robin: r0 and r1 both assert from reset and re-request after each done -> grant order r0, r1, r0, r1; done pulses never overlap; owner matches each grant.
- Wrap-around: r1 writes 0xAABBCCDD at 0x7FFFE -> bytes land at 0x7FFFE, 0x7FFFF, 0x00000, 0x00001 = DD, CC, BB, AA.
- Contention while busy: r1 asserts req during r0's XFER byte 2 -> r1 is granted in the IDLE cycle after r0_done; RAM port shows no interleaving of bytes.
- Reset abort: rst asserted after byte 1 of a write -> outputs 0 immediately, no done, bytes 0–1 written, bytes 2–3 unchanged; the next request after reset completes normally.
